wb_sdram_wbuf: RTL and testbench

Write-posting buffer on one Wishbone port in front of the SDRAM port arbiter. Accepts single (classic) writes from a CPU/bus master in one cycle into a small FIFO, then replays them to the arbiter port. Reads are forwarded only after all posted writes drain, so read-after-write ordering is preserved. Sits between a bus master and one `wb_*` slot of the SDRAM controller, in the `wb_clk` domain.

---
 rtl/wb_sdram_pkg.sv | 21 ++
 rtl/wb_sdram_wbuf_fifo.sv | 76 +++++++
 rtl/wb_sdram_wbuf.sv | 182 ++++++++++++++++++
 tb/tb_wb_sdram_wbuf.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_sdram_pkg.sv
// Shared types and constants for the SDRAM Wishbone write-posting buffer.
package wb_sdram_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StWr,
    StRd
  } mstate_e;

  localparam logic [2:0] CtiClassic = 3'b000;
  localparam logic [1:0] BteLinear  = 2'b00;

  localparam int unsigned DatWidth = 32;
  localparam int unsigned SelWidth = 4;

  // FIFO entry packs {adr, dat, sel}.
  function automatic int unsigned entry_width(int unsigned adr_width);
    return adr_width + DatWidth + SelWidth;
  endfunction

endpackage

// File: rtl/wb_sdram_wbuf_fifo.sv
// Register-array FIFO of posted writes with a tail-write port for merging.
module wb_sdram_wbuf_fifo
  import wb_sdram_pkg::*;
#(
  parameter int unsigned DepthLog2 = 2,
  parameter int unsigned AdrWidth  = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                push,
  input  logic [AdrWidth-1:0] push_adr,
  input  logic [31:0]         push_dat,
  input  logic [3:0]          push_sel,
  input  logic                pop,
  input  logic                merge,
  input  logic [31:0]         merge_dat,
  input  logic [3:0]          merge_sel,
  output logic [AdrWidth-1:0] head_adr,
  output logic [31:0]         head_dat,
  output logic [3:0]          head_sel,
  output logic [AdrWidth-1:0] tail_adr,
  output logic                full,
  output logic                empty,
  output logic                tail_is_head
);

  localparam int unsigned Depth  = 1 << DepthLog2;
  localparam int unsigned EntryW = entry_width(AdrWidth);
  localparam logic [DepthLog2:0] PtrOne = 1;

  logic [EntryW-1:0]    mem [Depth];
  logic [DepthLog2:0]   wr_ptr_q, rd_ptr_q, tail_ptr;
  logic [DepthLog2-1:0] wr_idx, rd_idx, tail_idx;
  logic [EntryW-1:0]    head, tail;

  assign wr_idx   = wr_ptr_q[DepthLog2-1:0];
  assign rd_idx   = rd_ptr_q[DepthLog2-1:0];
  assign tail_ptr = wr_ptr_q - PtrOne;
  assign tail_idx = tail_ptr[DepthLog2-1:0];

  assign empty        = (wr_ptr_q == rd_ptr_q);
  assign full         = (wr_ptr_q[DepthLog2] != rd_ptr_q[DepthLog2]) &&
                        (wr_idx == rd_idx);
  assign tail_is_head = ((wr_ptr_q - rd_ptr_q) == PtrOne);

  assign head     = mem[rd_idx];
  assign tail     = mem[tail_idx];
  assign head_adr = head[EntryW-1 -: AdrWidth];
  assign head_dat = head[SelWidth +: DatWidth];
  assign head_sel = head[SelWidth-1:0];
  assign tail_adr = tail[EntryW-1 -: AdrWidth];

  // Pointer update; push and pop may coincide.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PtrOne;
      if (pop)  rd_ptr_q <= rd_ptr_q + PtrOne;
    end
  end

  // Entry storage: push writes a fresh entry, merge overlays bytes on the tail.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_idx] <= {push_adr, push_dat, push_sel};
    end else if (merge) begin
      for (int b = 0; b < SelWidth; b++) begin
        if (merge_sel[b]) mem[tail_idx][SelWidth + 8*b +: 8] <= merge_dat[8*b +: 8];
      end
      mem[tail_idx][SelWidth-1:0] <= tail[SelWidth-1:0] | merge_sel;
    end
  end

endmodule

// File: rtl/wb_sdram_wbuf.sv
// Wishbone write-posting buffer in front of one SDRAM arbiter port.
// Optional write merging into the newest entry: define WB_SDRAM_WBUF_MERGE_EN.
module wb_sdram_wbuf
  import wb_sdram_pkg::*;
#(
  parameter int unsigned DEPTH_LOG2 = 2,
  parameter int unsigned ADR_WIDTH  = 32
) (
  input  logic                 wb_clk,
  input  logic                 wb_rst_n,
  input  logic [ADR_WIDTH-1:0] s_adr_i,
  input  logic [31:0]          s_dat_i,
  input  logic [3:0]           s_sel_i,
  input  logic                 s_we_i,
  input  logic                 s_stb_i,
  input  logic                 s_cyc_i,
  output logic [31:0]          s_dat_o,
  output logic                 s_ack_o,
  output logic [ADR_WIDTH-1:0] m_adr_o,
  output logic [31:0]          m_dat_o,
  output logic [3:0]           m_sel_o,
  output logic                 m_we_o,
  output logic                 m_stb_o,
  output logic                 m_cyc_o,
  output logic [2:0]           m_cti_o,
  output logic [1:0]           m_bte_o,
  input  logic [31:0]          m_dat_i,
  input  logic                 m_ack_i
);

  mstate_e              state_q, state_d;
  logic                 rd_pend_q, rd_pend_d;
  logic [ADR_WIDTH-1:0] rd_adr_q;
  logic [3:0]           rd_sel_q;
  logic                 s_ack_q, s_ack_d;
  logic [31:0]          s_dat_q, s_dat_d;
  logic [ADR_WIDTH-1:0] m_adr_q, m_adr_d;
  logic [31:0]          m_dat_q, m_dat_d;
  logic [3:0]           m_sel_q, m_sel_d;
  logic                 m_we_q, m_we_d;

  logic                 wr_req, rd_req, push, pop, merge, rd_done;
  logic [ADR_WIDTH-1:0] head_adr, tail_adr;
  logic [31:0]          head_dat;
  logic [3:0]           head_sel;
  logic                 fifo_full, fifo_empty, tail_is_head;
  logic                 unused_tail;

  assign wr_req = s_cyc_i & s_stb_i & s_we_i & ~s_ack_q & ~rd_pend_q;
  assign rd_req = s_cyc_i & s_stb_i & ~s_we_i & ~s_ack_q & ~rd_pend_q;

`ifdef WB_SDRAM_WBUF_MERGE_EN
  // A single-entry FIFO's tail is the head being (or about to be) replayed.
  assign merge = wr_req & ~fifo_empty & ~tail_is_head &
                 (s_adr_i[ADR_WIDTH-1:2] == tail_adr[ADR_WIDTH-1:2]);
  assign unused_tail = ^tail_adr[1:0];
`else
  assign merge = 1'b0;
  assign unused_tail = ^{tail_adr, tail_is_head};
`endif

  assign push = wr_req & ~fifo_full & ~merge;

  wb_sdram_wbuf_fifo #(
    .DepthLog2 (DEPTH_LOG2),
    .AdrWidth  (ADR_WIDTH)
  ) u_fifo (
    .clk          (wb_clk),
    .rst_n        (wb_rst_n),
    .push         (push),
    .push_adr     (s_adr_i),
    .push_dat     (s_dat_i),
    .push_sel     (s_sel_i),
    .pop          (pop),
    .merge        (merge),
    .merge_dat    (s_dat_i),
    .merge_sel    (s_sel_i),
    .head_adr     (head_adr),
    .head_dat     (head_dat),
    .head_sel     (head_sel),
    .tail_adr     (tail_adr),
    .full         (fifo_full),
    .empty        (fifo_empty),
    .tail_is_head (tail_is_head)
  );

  // Master FSM: drain posted writes first, then issue a pending read.
  always_comb begin
    state_d = state_q;
    m_adr_d = m_adr_q;
    m_dat_d = m_dat_q;
    m_sel_d = m_sel_q;
    m_we_d  = m_we_q;
    s_dat_d = s_dat_q;
    pop     = 1'b0;
    rd_done = 1'b0;
    case (state_q)
      StIdle: begin
        if (!fifo_empty) begin
          state_d = StWr;
          m_adr_d = head_adr;
          m_dat_d = head_dat;
          m_sel_d = head_sel;
          m_we_d  = 1'b1;
        end else if (rd_pend_q && s_cyc_i) begin
          state_d = StRd;
          m_adr_d = rd_adr_q;
          m_sel_d = rd_sel_q;
          m_we_d  = 1'b0;
        end
      end
      StWr: begin
        if (m_ack_i) begin
          pop     = 1'b1;
          state_d = StIdle;
        end
      end
      StRd: begin
        if (m_ack_i) begin
          s_dat_d = m_dat_i;
          rd_done = 1'b1;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Slave-side ack and read-pending tracking; an abandoned read is forgotten before RD.
  always_comb begin
    s_ack_d   = push | merge | (rd_done & s_cyc_i);
    rd_pend_d = rd_pend_q;
    if (rd_done) begin
      rd_pend_d = 1'b0;
    end else if (rd_pend_q && !s_cyc_i && state_q != StRd) begin
      rd_pend_d = 1'b0;
    end else if (rd_req) begin
      rd_pend_d = 1'b1;
    end
  end

  // State and output registers.
  always_ff @(posedge wb_clk) begin
    if (!wb_rst_n) begin
      state_q   <= StIdle;
      rd_pend_q <= 1'b0;
      rd_adr_q  <= '0;
      rd_sel_q  <= '0;
      s_ack_q   <= 1'b0;
      s_dat_q   <= '0;
      m_adr_q   <= '0;
      m_dat_q   <= '0;
      m_sel_q   <= '0;
      m_we_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      rd_pend_q <= rd_pend_d;
      if (rd_req) begin
        rd_adr_q <= s_adr_i;
        rd_sel_q <= s_sel_i;
      end
      s_ack_q   <= s_ack_d;
      s_dat_q   <= s_dat_d;
      m_adr_q   <= m_adr_d;
      m_dat_q   <= m_dat_d;
      m_sel_q   <= m_sel_d;
      m_we_q    <= m_we_d;
    end
  end

  assign s_ack_o = s_ack_q;
  assign s_dat_o = s_dat_q;
  assign m_adr_o = m_adr_q;
  assign m_dat_o = m_dat_q;
  assign m_sel_o = m_sel_q;
  assign m_we_o  = m_we_q;
  assign m_stb_o = (state_q != StIdle);
  assign m_cyc_o = (state_q != StIdle);
  assign m_cti_o = CtiClassic;
  assign m_bte_o = BteLinear;

endmodule

// File: tb/tb_wb_sdram_wbuf.sv
// Scoreboard bench for wb_sdram_wbuf: expected master cycles and read data are queued
// by the stimulus and checked by an independent monitor.
module tb_wb_sdram_wbuf;

  logic        wb_clk = 1'b0;
  logic        wb_rst_n = 1'b0;
  logic [31:0] s_adr_i = '0, s_dat_i = '0;
  logic [3:0]  s_sel_i = '0;
  logic        s_we_i = 1'b0, s_stb_i = 1'b0, s_cyc_i = 1'b0;
  logic [31:0] s_dat_o, m_adr_o, m_dat_o;
  logic        s_ack_o, m_we_o, m_stb_o, m_cyc_o;
  logic [3:0]  m_sel_o;
  logic [2:0]  m_cti_o;
  logic [1:0]  m_bte_o;
  logic [31:0] m_dat_i = '0;
  logic        m_ack_i = 1'b0;

  always #5 wb_clk = ~wb_clk;

  wb_sdram_wbuf #(
    .DEPTH_LOG2 (2),
    .ADR_WIDTH  (32)
  ) dut (
    .wb_clk   (wb_clk),
    .wb_rst_n (wb_rst_n),
    .s_adr_i  (s_adr_i),
    .s_dat_i  (s_dat_i),
    .s_sel_i  (s_sel_i),
    .s_we_i   (s_we_i),
    .s_stb_i  (s_stb_i),
    .s_cyc_i  (s_cyc_i),
    .s_dat_o  (s_dat_o),
    .s_ack_o  (s_ack_o),
    .m_adr_o  (m_adr_o),
    .m_dat_o  (m_dat_o),
    .m_sel_o  (m_sel_o),
    .m_we_o   (m_we_o),
    .m_stb_o  (m_stb_o),
    .m_cyc_o  (m_cyc_o),
    .m_cti_o  (m_cti_o),
    .m_bte_o  (m_bte_o),
    .m_dat_i  (m_dat_i),
    .m_ack_i  (m_ack_i)
  );

  typedef struct packed {
    logic [31:0] adr;
    logic [31:0] dat;
    logic [3:0]  sel;
    logic        we;
  } mtxn_t;

  mtxn_t       exp_m[$];
  logic [31:0] exp_rd[$];
  int          checks = 0;
  int          errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic exp_wr(input logic [31:0] adr, input logic [31:0] dat, input logic [3:0] sel);
    exp_m.push_back('{adr: adr, dat: dat, sel: sel, we: 1'b1});
  endtask

  // Arbiter model: acks a strobe after ack_dly wait cycles when enabled.
  logic        ack_en = 1'b0;
  int          ack_dly = 0;
  logic [31:0] rd_data = '0;
  initial begin
    int cnt = 0;
    forever begin
      @(posedge wb_clk); #1;
      if (m_ack_i || !wb_rst_n) begin
        m_ack_i = 1'b0;
        cnt = 0;
      end else if (m_stb_o && ack_en) begin
        if (cnt >= ack_dly) begin
          m_ack_i = 1'b1;
          m_dat_i = rd_data;
          cnt = 0;
        end else begin
          cnt++;
        end
      end else begin
        cnt = 0;
      end
    end
  end

  // Monitor: compare each new master cycle and each read ack against the queues.
  logic  prev_stb = 1'b0, prev_sack = 1'b0, prev_mack = 1'b0;
  mtxn_t mon_t;
  always @(negedge wb_clk) begin
    if (wb_rst_n) begin
      if (m_stb_o && !prev_stb) begin
        if (exp_m.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_m_cycle: adr 0x%0h we %0b with nothing queued", m_adr_o,
                   m_we_o);
        end else begin
          mon_t = exp_m.pop_front();
          check("m_adr", m_adr_o, mon_t.adr);
          check("m_sel", m_sel_o, mon_t.sel);
          check("m_we", m_we_o, mon_t.we);
          if (mon_t.we) check("m_dat", m_dat_o, mon_t.dat);
          check("m_cyc", m_cyc_o, 1);
          check("m_cti_bte", {m_cti_o, m_bte_o}, 0);
        end
      end
      if (s_ack_o) begin
        check("s_ack_single_cycle", prev_sack, 0);
        if (!s_we_i) begin
          check("rd_ack_after_m_ack", prev_mack, 1);
          if (exp_rd.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_rd_ack: data 0x%0h", s_dat_o);
          end else begin
            check("rd_data", s_dat_o, exp_rd.pop_front());
          end
        end
      end
    end
    prev_stb  = m_stb_o;
    prev_sack = s_ack_o;
    prev_mack = m_ack_i;
  end

  // One slave transfer; returns cycles from request to ack, then idles one cycle.
  task automatic wb_xfer(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                         input logic [3:0] sel, output int lat);
    s_adr_i = adr;
    s_dat_i = dat;
    s_sel_i = sel;
    s_we_i  = we;
    s_cyc_i = 1'b1;
    s_stb_i = 1'b1;
    lat = 0;
    do begin
      @(posedge wb_clk); #1;
      lat++;
    end while (!s_ack_o && lat < 300);
    if (!s_ack_o) begin
      checks++;
      errors++;
      $display("FAIL wb_xfer_timeout: no s_ack for adr 0x%0h after %0d cycles", adr, lat);
    end
    s_cyc_i = 1'b0;
    s_stb_i = 1'b0;
    @(posedge wb_clk); #1;
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while ((exp_m.size() != 0 || m_stb_o) && n < 300) begin
      @(posedge wb_clk); #1;
      n++;
    end
    checks++;
    if (n >= 300) begin
      errors++;
      $display("FAIL %s_drain: %0d master cycles still expected, stb=%0b", name, exp_m.size(),
               m_stb_o);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int lat, lat5;

    // Reset with a live write request on the slave side.
    s_cyc_i = 1'b1; s_stb_i = 1'b1; s_we_i = 1'b1;
    s_adr_i = 32'h55; s_dat_i = 32'hCAFE; s_sel_i = 4'hF;
    repeat (2) @(posedge wb_clk);
    #1;
    check("rst_s_ack", s_ack_o, 0);
    check("rst_s_dat", s_dat_o, 0);
    check("rst_m_stb", m_stb_o, 0);
    check("rst_m_cyc", m_cyc_o, 0);
    check("rst_m_we", m_we_o, 0);
    check("rst_m_adr", m_adr_o, 0);
    check("rst_m_dat", m_dat_o, 0);
    check("rst_m_sel", m_sel_o, 0);
    s_cyc_i = 1'b0; s_stb_i = 1'b0;
    wb_rst_n = 1'b1;
    @(posedge wb_clk); #1;
    check("post_rst_idle_stb", m_stb_o, 0);

    // Single posted write.
    ack_en = 1'b1; ack_dly = 1;
    exp_wr(32'h100, 32'hDEADBEEF, 4'hF);
    wb_xfer(1'b1, 32'h100, 32'hDEADBEEF, 4'hF, lat);
    check("single_wr_ack_latency", lat, 1);
    check("single_wr_stb_at_n2", m_stb_o, 1);
    wait_drain("single");

    // Fill the FIFO with the arbiter stalled; the fifth write waits for a pop.
    ack_en = 1'b0; ack_dly = 0;
    for (int i = 0; i < 5; i++) exp_wr(32'h1000 + 4*i, 32'hA000_0000 + i, 4'hF);
    for (int i = 0; i < 4; i++) begin
      wb_xfer(1'b1, 32'h1000 + 4*i, 32'hA000_0000 + i, 4'hF, lat);
      check("fill_wr_ack_latency", lat, 1);
    end
    fork
      wb_xfer(1'b1, 32'h1010, 32'hA000_0004, 4'hF, lat5);
      begin
        repeat (8) @(posedge wb_clk);
        #1 ack_en = 1'b1;
      end
    join
    check("fill_fifth_stalled", lat5 > 8, 1);
    wait_drain("fill");

    // Read after two posted writes: issued only once both writes have drained.
    ack_dly = 2; rd_data = 32'h12345678;
    exp_wr(32'h200, 32'h1111_1111, 4'hF);
    exp_wr(32'h200, 32'h2222_2222, 4'hF);
    exp_m.push_back('{adr: 32'h200, dat: 32'h0, sel: 4'hF, we: 1'b0});
    exp_rd.push_back(32'h12345678);
    wb_xfer(1'b1, 32'h200, 32'h1111_1111, 4'hF, lat);
    wb_xfer(1'b1, 32'h200, 32'h2222_2222, 4'hF, lat);
    check("raw_second_wr_latency", lat, 1);
    wb_xfer(1'b0, 32'h200, 32'h0, 4'hF, lat);
    check("raw_rd_data_held", s_dat_o, 32'h12345678);
    wait_drain("raw");

    // Same-word writes behind a stalled head.
    ack_en = 1'b0; ack_dly = 0;
    exp_wr(32'h2F0, 32'h5555_5555, 4'hF);
`ifdef WB_SDRAM_WBUF_MERGE_EN
    exp_wr(32'h300, 32'hBBBBAAAA, 4'hF);
`else
    exp_wr(32'h300, 32'h0000AAAA, 4'h3);
    exp_wr(32'h300, 32'hBBBB0000, 4'hC);
`endif
    wb_xfer(1'b1, 32'h2F0, 32'h5555_5555, 4'hF, lat);
    wb_xfer(1'b1, 32'h300, 32'h0000AAAA, 4'h3, lat);
    check("merge_first_latency", lat, 1);
    wb_xfer(1'b1, 32'h300, 32'hBBBB0000, 4'hC, lat);
    check("merge_second_latency", lat, 1);
    ack_en = 1'b1;
    wait_drain("merge");

    // Reset while draining: queued writes are discarded.
    ack_en = 1'b0;
    exp_wr(32'h400, 32'h4000_0000, 4'hF);
    wb_xfer(1'b1, 32'h400, 32'h4000_0000, 4'hF, lat);
    wb_xfer(1'b1, 32'h404, 32'h4000_0001, 4'hF, lat);
    wb_xfer(1'b1, 32'h408, 32'h4000_0002, 4'hF, lat);
    check("pre_rst_in_wr", m_stb_o, 1);
    wb_rst_n = 1'b0;
    @(posedge wb_clk); #1;
    check("rst_drops_stb", m_stb_o, 0);
    wb_rst_n = 1'b1;
    ack_en = 1'b1;
    repeat (20) @(posedge wb_clk);
    #1;
    check("post_rst_no_cycles", m_stb_o, 0);
    check("leftover_m_expect", exp_m.size(), 0);
    check("leftover_rd_expect", exp_rd.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
